// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC pipeline: opcodes, flag layout, stage state.
package wisc_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 0;

  localparam logic [OP_W-1:0] OP_ADD    = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB    = 4'b0001;
  localparam logic [OP_W-1:0] OP_XOR    = 4'b0010;
  localparam logic [OP_W-1:0] OP_RED    = 4'b0011;
  localparam logic [OP_W-1:0] OP_SLL    = 4'b0100;
  localparam logic [OP_W-1:0] OP_SRA    = 4'b0101;
  localparam logic [OP_W-1:0] OP_ROR    = 4'b0110;
  localparam logic [OP_W-1:0] OP_PADDSB = 4'b0111;
  localparam logic [OP_W-1:0] OP_LW     = 4'b1000;
  localparam logic [OP_W-1:0] OP_SW     = 4'b1001;
  localparam logic [OP_W-1:0] OP_LHB    = 4'b1010;
  localparam logic [OP_W-1:0] OP_LLB    = 4'b1011;
  localparam logic [OP_W-1:0] OP_B      = 4'b1100;
  localparam logic [OP_W-1:0] OP_BR     = 4'b1101;
  localparam logic [OP_W-1:0] OP_PCS    = 4'b1110;
  localparam logic [OP_W-1:0] OP_HLT    = 4'b1111;

  typedef enum logic {
    StRun,
    StHalted
  } stage_state_e;

  // Which flag bits an opcode writes when it retires from EX.
  function automatic logic [FLAG_W-1:0] flag_mask(input logic [OP_W-1:0] op);
    logic [FLAG_W-1:0] m;
    m = '0;
    case (op)
      OP_ADD, OP_SUB:                 m = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m[FLAG_Z] = 1'b1;
      default:                        m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ex_mem_stage_flag_reg.sv
// Architectural flag register with per-bit write mask.
// Optional same-cycle bypass to the branch unit when FLAG_BYPASS_EN is defined.
module flag_reg
  import wisc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLAG_W-1:0] upd_mask_i,
  input  logic [FLAG_W-1:0] flag_i,
  output logic [FLAG_W-1:0] flag_q_o,
  output logic [FLAG_W-1:0] flag_fwd_o
);

  logic [FLAG_W-1:0] r_flag;
  logic [FLAG_W-1:0] w_flag_next;

  // Merge: masked bits take the new ALU flags, the rest hold.
  always_comb begin
    w_flag_next = (upd_mask_i & flag_i) | (~upd_mask_i & r_flag);
  end

  // Flag state, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flag <= '0;
    end else begin
      r_flag <= w_flag_next;
    end
  end

  assign flag_q_o = r_flag;

`ifdef FLAG_BYPASS_EN
  // Mask is zero unless an updating opcode is accepted, so this equals r_flag otherwise.
  assign flag_fwd_o = w_flag_next;
`else
  assign flag_fwd_o = r_flag;
`endif

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with flag update and HLT handling.
// Optional macro FLAG_BYPASS_EN enables same-cycle flag forwarding in flag_reg.
module ex_mem_stage
  import wisc_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [OP_W-1:0]   ex_opcode_i,
  input  logic [DATA_W-1:0] alu_out_i,
  input  logic [FLAG_W-1:0] alu_flag_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_regwrite_i,
  input  logic              ex_memread_i,
  input  logic              ex_memwrite_i,
  input  logic [DATA_W-1:0] ex_store_data_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              mem_valid_o,
  output logic [OP_W-1:0]   mem_opcode_o,
  output logic [DATA_W-1:0] mem_alu_result_o,
  output logic [REG_AW-1:0] mem_rd_o,
  output logic              mem_regwrite_o,
  output logic              mem_memread_o,
  output logic              mem_memwrite_o,
  output logic [DATA_W-1:0] mem_store_data_o,
  output logic [FLAG_W-1:0] flag_q_o,
  output logic [FLAG_W-1:0] flag_fwd_o,
  output logic              halted_o
);

  stage_state_e      r_state;
  logic              r_halted;
  logic              r_valid;
  logic [OP_W-1:0]   r_opcode;
  logic [DATA_W-1:0] r_alu_result;
  logic [REG_AW-1:0] r_rd;
  logic              r_regwrite;
  logic              r_memread;
  logic              r_memwrite;
  logic [DATA_W-1:0] r_store_data;

  logic              w_run;
  logic              w_accept;
  logic              w_is_hlt;
  logic [FLAG_W-1:0] w_flag_mask;

  assign w_run      = (r_state == StRun);
  assign w_accept   = ex_valid_i & ~stall_i & ~flush_i & w_run;
  assign w_is_hlt   = (ex_opcode_i == OP_HLT);
  assign ex_ready_o = ~stall_i;

  // Flag write mask is only live on an accepted instruction.
  always_comb begin
    w_flag_mask = '0;
    if (w_accept) begin
      w_flag_mask = flag_mask(ex_opcode_i);
    end
  end

  // EX/MEM register: reset > flush > stall > accept > bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_opcode     <= '0;
      r_alu_result <= '0;
      r_rd         <= '0;
      r_regwrite   <= 1'b0;
      r_memread    <= 1'b0;
      r_memwrite   <= 1'b0;
      r_store_data <= '0;
    end else if (flush_i) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
    end else if (stall_i) begin
      r_valid    <= r_valid;
      r_regwrite <= r_regwrite;
      r_memread  <= r_memread;
      r_memwrite <= r_memwrite;
    end else if (w_accept) begin
      r_valid      <= 1'b1;
      r_opcode     <= ex_opcode_i;
      r_alu_result <= alu_out_i;
      r_rd         <= ex_rd_i;
      // HLT travels down the pipe but must never write anything.
      r_regwrite   <= ex_regwrite_i & ~w_is_hlt;
      r_memread    <= ex_memread_i;
      r_memwrite   <= ex_memwrite_i & ~w_is_hlt;
      r_store_data <= ex_store_data_i;
    end else begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
    end
  end

  // RUN/HALTED state machine; HALTED exits only through reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= StRun;
      r_halted <= 1'b0;
    end else begin
      unique case (r_state)
        StRun: begin
          if (w_accept && w_is_hlt) begin
            r_state  <= StHalted;
            r_halted <= 1'b1;
          end
        end
        StHalted: begin
          r_state  <= StHalted;
          r_halted <= 1'b1;
        end
        default: begin
          r_state  <= StRun;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  flag_reg u_flag_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd_mask_i (w_flag_mask),
    .flag_i     (alu_flag_i),
    .flag_q_o   (flag_q_o),
    .flag_fwd_o (flag_fwd_o)
  );

  assign mem_valid_o      = r_valid;
  assign mem_opcode_o     = r_opcode;
  assign mem_alu_result_o = r_alu_result;
  assign mem_rd_o         = r_rd;
  assign mem_regwrite_o   = r_regwrite;
  assign mem_memread_o    = r_memread;
  assign mem_memwrite_o   = r_memwrite;
  assign mem_store_data_o = r_store_data;
  assign halted_o         = r_halted;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed table-driven bench for ex_mem_stage plus hand-written multi-cycle sequences.
module tb_ex_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [3:0]  ex_opcode_i;
  logic [15:0] alu_out_i;
  logic [2:0]  alu_flag_i;
  logic [3:0]  ex_rd_i;
  logic        ex_regwrite_i;
  logic        ex_memread_i;
  logic        ex_memwrite_i;
  logic [15:0] ex_store_data_i;
  logic        stall_i;
  logic        flush_i;
  logic        mem_valid_o;
  logic [3:0]  mem_opcode_o;
  logic [15:0] mem_alu_result_o;
  logic [3:0]  mem_rd_o;
  logic        mem_regwrite_o;
  logic        mem_memread_o;
  logic        mem_memwrite_o;
  logic [15:0] mem_store_data_o;
  logic [2:0]  flag_q_o;
  logic [2:0]  flag_fwd_o;
  logic        halted_o;

  int n_checks;
  int n_fail;

  ex_mem_stage #(
    .DATA_W (16),
    .REG_AW (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_valid_i       (ex_valid_i),
    .ex_ready_o       (ex_ready_o),
    .ex_opcode_i      (ex_opcode_i),
    .alu_out_i        (alu_out_i),
    .alu_flag_i       (alu_flag_i),
    .ex_rd_i          (ex_rd_i),
    .ex_regwrite_i    (ex_regwrite_i),
    .ex_memread_i     (ex_memread_i),
    .ex_memwrite_i    (ex_memwrite_i),
    .ex_store_data_i  (ex_store_data_i),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .mem_valid_o      (mem_valid_o),
    .mem_opcode_o     (mem_opcode_o),
    .mem_alu_result_o (mem_alu_result_o),
    .mem_rd_o         (mem_rd_o),
    .mem_regwrite_o   (mem_regwrite_o),
    .mem_memread_o    (mem_memread_o),
    .mem_memwrite_o   (mem_memwrite_o),
    .mem_store_data_o (mem_store_data_o),
    .flag_q_o         (flag_q_o),
    .flag_fwd_o       (flag_fwd_o),
    .halted_o         (halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [15:0] alu;
    logic [2:0]  flg;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        stall;
    logic        flush;
    logic        e_ready;
    logic [2:0]  e_fwd_byp;
    logic        e_valid;
    logic        e_rw;
    logic        e_mr;
    logic        e_mw;
    logic        chk_data;
    logic [2:0]  e_flag;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] alu,
                       input logic [2:0] flg, input logic rw, input logic mr, input logic mw,
                       input logic st, input logic fl, input logic rn);
    ex_valid_i      = v;
    ex_opcode_i     = op;
    alu_out_i       = alu;
    alu_flag_i      = flg;
    ex_rd_i         = alu[3:0];
    ex_regwrite_i   = rw;
    ex_memread_i    = mr;
    ex_memwrite_i   = mw;
    ex_store_data_i = ~alu;
    stall_i         = st;
    flush_i         = fl;
    rst_n           = rn;
  endtask

  // Forwarded flags expected this cycle given bypass value and current flag_q.
  function automatic logic [2:0] fwd_exp(input logic [2:0] byp, input logic [2:0] old);
`ifdef FLAG_BYPASS_EN
    return byp;
`else
    return old;
`endif
  endfunction

  task automatic chk_ctrl(input string tag, input logic v, input logic rw, input logic mr,
                          input logic mw, input logic [2:0] fl, input logic h);
    chk({tag, ".valid"}, {31'd0, mem_valid_o}, {31'd0, v});
    chk({tag, ".regwrite"}, {31'd0, mem_regwrite_o}, {31'd0, rw});
    chk({tag, ".memread"}, {31'd0, mem_memread_o}, {31'd0, mr});
    chk({tag, ".memwrite"}, {31'd0, mem_memwrite_o}, {31'd0, mw});
    chk({tag, ".flag_q"}, {29'd0, flag_q_o}, {29'd0, fl});
    chk({tag, ".halted"}, {31'd0, halted_o}, {31'd0, h});
  endtask

  task automatic chk_all_zero(input string tag);
    chk_ctrl(tag, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    chk({tag, ".opcode"}, {28'd0, mem_opcode_o}, 32'd0);
    chk({tag, ".alu"}, {16'd0, mem_alu_result_o}, 32'd0);
    chk({tag, ".rd"}, {28'd0, mem_rd_o}, 32'd0);
    chk({tag, ".store"}, {16'd0, mem_store_data_o}, 32'd0);
  endtask

  logic [2:0] prev_flag;

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //             v  op       alu       flg     rw mr mw st fl rdy fwdb   ev erw emr emw cd ef
    vecs[0] = '{1'b1, 4'b0000, 16'h1234, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b1, 3'b110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b110};
    vecs[1] = '{1'b1, 4'b0001, 16'h0001, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b1, 3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b011};
    vecs[2] = '{1'b1, 4'b0010, 16'hAAAA, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b1, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b111};
    vecs[3] = '{1'b1, 4'b1000, 16'h0040, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                1'b1, 3'b111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b111};
    vecs[4] = '{1'b1, 4'b0101, 16'h8000, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b1, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b111};
    vecs[5] = '{1'b1, 4'b1001, 16'h0044, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                1'b1, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b111};
    vecs[6] = '{1'b0, 4'b0000, 16'h0000, 3'b011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111};
    vecs[7] = '{1'b1, 4'b0000, 16'h8000, 3'b011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111};
    vecs[8] = '{1'b1, 4'b0110, 16'h0F0F, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b1, 3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b011};

    // Reset
    drive(1'b1, 4'b0000, 16'hFFFF, 3'b111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all_zero("reset");
    prev_flag = 3'b000;

    // Table
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].op, vecs[i].alu, vecs[i].flg, vecs[i].rw, vecs[i].mr,
            vecs[i].mw, vecs[i].stall, vecs[i].flush, 1'b1);
      #1;
      chk($sformatf("v%0d.ready", i), {31'd0, ex_ready_o}, {31'd0, vecs[i].e_ready});
      chk($sformatf("v%0d.fwd", i), {29'd0, flag_fwd_o},
          {29'd0, fwd_exp(vecs[i].e_fwd_byp, prev_flag)});
      @(posedge clk);
      #1;
      chk_ctrl($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_rw, vecs[i].e_mr, vecs[i].e_mw,
               vecs[i].e_flag, 1'b0);
      if (vecs[i].chk_data) begin
        chk($sformatf("v%0d.opcode", i), {28'd0, mem_opcode_o}, {28'd0, vecs[i].op});
        chk($sformatf("v%0d.alu", i), {16'd0, mem_alu_result_o}, {16'd0, vecs[i].alu});
        chk($sformatf("v%0d.rd", i), {28'd0, mem_rd_o}, {28'd0, vecs[i].alu[3:0]});
        chk($sformatf("v%0d.store", i), {16'd0, mem_store_data_o}, {16'd0, ~vecs[i].alu});
      end
      prev_flag = vecs[i].e_flag;
    end

    // SUB held by stall for 3 cycles: ROR result stays in MEM
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1'b1, 4'b0001, 16'h5555, 3'b100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      #1;
      chk("stall.ready", {31'd0, ex_ready_o}, 32'd0);
      @(posedge clk);
      #1;
      chk_ctrl("stall", 1'b1, 1'b1, 1'b0, 1'b0, 3'b011, 1'b0);
      chk("stall.alu", {16'd0, mem_alu_result_o}, 32'h0F0F);
    end
    @(negedge clk);
    stall_i = 1'b0;
    #1;
    chk("release.ready", {31'd0, ex_ready_o}, 32'd1);
    chk("release.fwd", {29'd0, flag_fwd_o}, {29'd0, fwd_exp(3'b100, 3'b011)});
    @(posedge clk);
    #1;
    chk_ctrl("release", 1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0);
    chk("release.alu", {16'd0, mem_alu_result_o}, 32'h5555);
    chk("release.opcode", {28'd0, mem_opcode_o}, 32'h1);

    // HLT together with flush is killed, state stays RUN
    @(negedge clk);
    drive(1'b1, 4'b1111, 16'h0BAD, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk_ctrl("flushhlt", 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0);

    // HLT accepted: travels with writes suppressed
    @(negedge clk);
    drive(1'b1, 4'b1111, 16'h0BAD, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk_ctrl("hlt", 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1);
    chk("hlt.opcode", {28'd0, mem_opcode_o}, 32'hF);

    // ADD while halted becomes a bubble; flags frozen
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(1'b1, 4'b0000, 16'h7777, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      chk("halted.ready", {31'd0, ex_ready_o}, 32'd1);
      chk("halted.fwd", {29'd0, flag_fwd_o}, 32'd4);
      @(posedge clk);
      #1;
      chk_ctrl("halted", 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1);
    end

    // Reset while halted
    @(negedge clk);
    drive(1'b1, 4'b0000, 16'h7777, 3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all_zero("rst_halted");

    // Back in RUN: ADD accepted
    @(negedge clk);
    drive(1'b1, 4'b0000, 16'h7FFF, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk_ctrl("rerun", 1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0);
    chk("rerun.alu", {16'd0, mem_alu_result_o}, 32'h7FFF);

    // Reset during a stall discards the in-flight instruction
    @(negedge clk);
    drive(1'b1, 4'b0001, 16'h1111, 3'b110, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("rst_stall");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter DATA_W, default 16, datapath width of the ALU result and store data.
REQ-002 Parameter REG_AW, default 4, destination register address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 ex_valid_i  input  1  EX holds a real instruction.
REQ-006 ex_ready_o  output  1  stage accepts EX this cycle; equals !stall_i.
REQ-007 ex_opcode_i  input  4  instruction opcode, ISA encoding 0000 ADD ... 1111 HLT.
REQ-008 alu_out_i  input  DATA_W  ALU result.
REQ-009 alu_flag_i  input  3  ALU flags: [2]=Z, [1]=V, [0]=N.
REQ-010 ex_rd_i / ex_regwrite_i / ex_memread_i / ex_memwrite_i  input  REG_AW/1/1/1  destination and control.
REQ-011 ex_store_data_i  input  DATA_W  SW data.
REQ-012 stall_i  input  1  downstream hazard hold.
REQ-013 flush_i  input  1  kill the EX instruction.
REQ-014 mem_valid_o, mem_opcode_o, mem_alu_result_o, mem_rd_o, mem_regwrite_o, mem_memread_o, mem_memwrite_o, mem_store_data_o  output  registered EX/MEM copies of the inputs above.
REQ-015 flag_q_o  output  3  architectural flag register.
REQ-016 flag_fwd_o  output  3  flags seen by a branch in ID this cycle.
REQ-017 halted_o  output  1  HLT has been accepted.

Function
REQ-018 Accept = ex_valid_i & !stall_i & !flush_i & state==RUN.
REQ-019 Priority per cycle: reset > flush > stall > accept > bubble.
REQ-020 Accept: all mem_* registers load from EX inputs next edge; mem_valid_o=1; latency exactly 1 cycle.
REQ-021 Stall without flush: all mem_* registers and flag_q_o hold; ex_ready_o=0.
REQ-022 Flush (regardless of stall): mem_valid_o=0, mem_regwrite_o=0, mem_memread_o=0, mem_memwrite_o=0 next edge; flags untouched.
REQ-023 Not accepted, not stalled: bubble, with the same cleared controls as REQ-022.
REQ-024 Flag update only on accept: ADD(0000)/SUB(0001) load all three bits; XOR(0010)/SLL(0100)/SRA(0101)/ROR(0110) load Z only, N and V hold; all other opcodes, including LW/SW, leave flags unchanged.
REQ-025 State machine RUN/HALTED: RUN->HALTED on accepting opcode 1111; HALTED is left only by reset.
REQ-026 The HLT instruction itself propagates to MEM with mem_regwrite_o=0 and mem_memwrite_o=0.
REQ-027 halted_o=1 from the edge after HLT is accepted.
REQ-028 In HALTED: ex_ready_o follows REQ-006, every input produces a bubble, flags are frozen.
REQ-029 Simultaneous flush and HLT in EX: HLT is killed and state stays RUN.
REQ-030 No arithmetic; data fields pass through unmodified at full width.

Reset
REQ-031 On rst_n=0 at an edge: all mem_* outputs=0, flag_q_o=3'b000, state=RUN, halted_o=0.
REQ-032 Reset mid-stall or while HALTED gives the same result as REQ-031, and the in-flight instruction is discarded.

Configuration
REQ-033 Macro FLAG_BYPASS_EN defined: flag_fwd_o combinationally equals the merged next-flag value (REQ-024) when an accept of a flag-updating opcode occurs this cycle, otherwise flag_q_o.
REQ-034 Macro FLAG_BYPASS_EN undefined: flag_fwd_o = flag_q_o always; the hazard unit inserts one bubble before flag-dependent branches.

Structure
REQ-035 Shared package wisc_pkg holds: opcode constants, flag bit indices FLAG_Z=2 / FLAG_V=1 / FLAG_N=0, FLAG_W=3, and the stage state enum.
REQ-036 One sub-module flag_reg implements the 3-bit register with a per-bit update mask and the optional bypass; all other logic is inline.

Verification
REQ-037 ADD, alu_flag_i=3'b110, accepted -> next cycle flag_q_o=3'b110, mem_valid_o=1, mem_alu_result_o=alu_out_i.
REQ-038 Flags 3'b011, then XOR with alu_flag_i=3'b100 -> flag_q_o=3'b111; then LW with alu_flag_i=3'b000 -> flag_q_o stays 3'b111.
REQ-039 stall_i=1 for 3 cycles with SUB in EX -> mem_* and flags hold, ex_ready_o=0; release -> SUB lands one cycle later.
REQ-040 flush_i=1 and stall_i=1 with ADD 0x7FFF+1 -> mem_valid_o=0, flags unchanged.
REQ-041 HLT accepted, then ADD valid -> halted_o=1, ADD becomes a bubble, flags frozen; rst_n=0 -> all outputs 0, state RUN.
REQ-042 With FLAG_BYPASS_EN defined, accept SUB with alu_flag_i=3'b100 -> flag_fwd_o=3'b100 in the same cycle; undefined -> old flag_q_o.
